// File: rtl/cpu10_pkg.sv
// ============================================================================
// cpu10_pkg : shared widths, FSM encoding and defaults for the 10-bit core
// Revision  : 1.0
// ============================================================================
`default_nettype none

package cpu10_pkg;

  localparam int CPU10_DATA_W    = 10;
  localparam int CPU10_ADDR_W    = 10;
  localparam int DEF_WAIT_STATES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/data_ram_sp.sv
// ============================================================================
// data_ram_sp : single-port synchronous RAM, write-enable, registered read
// Revision    : 1.0
// ============================================================================
`default_nettype none

module data_ram_sp #(
  parameter int DATA_W     = 10,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : load/store responder with configurable wait states
// Revision           : 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
  import cpu10_pkg::*;
#(
  parameter int DATA_W      = CPU10_DATA_W,
  parameter int ADDR_W      = CPU10_ADDR_W,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              err
);

  mem_state_t        state, state_nxt;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              re_c, we_c;
  logic [DATA_W-1:0] rdata_r, ram_q, rdata_done;
  logic              req, access;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_we, load_c, oor_c;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) != '0;
  endfunction

  // Gating with reset keeps stall low and the RAM idle while reset is held.
  assign req = (req_re | req_we) & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = DONE;
            access    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 3'd1) begin
          state_nxt = DONE;
          access    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access fires straight from the live request.
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_c;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_c;
  assign acc_we    = (state == IDLE) ? req_we    : we_c;

  data_ram_sp #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (access),
    .we    (acc_we & ~out_of_range(acc_addr)),
    .addr  (acc_addr[DEPTH_LOG2-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 3'd0;
      addr_c  <= '0;
      wdata_c <= '0;
      re_c    <= 1'b0;
      we_c    <= 1'b0;
      rdata_r <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cnt     <= 3'(WAIT_STATES);
          addr_c  <= req_addr;
          wdata_c <= req_wdata;
          re_c    <= req_re;
          we_c    <= req_we;
        end
        WAIT:    cnt <= cnt - 3'd1;
        DONE:    if (load_c) rdata_r <= rdata_done;
        default: ;
      endcase
    end
  end

  assign load_c      = re_c & ~we_c;
  assign oor_c       = out_of_range(addr_c);
  assign rdata_done  = oor_c ? '0 : ram_q;
  assign rdata       = (state == DONE && load_c) ? rdata_done : rdata_r;
  assign rdata_valid = (state == DONE) && load_c;
  assign err         = (state == DONE) && (oor_c || (re_c && we_c));

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the 10-bit core's execute/memory stage. It accepts load/store requests driven from the EX/MEM/WB pipeline register outputs: ALU result as address, store data, and read enable, plus a write enable. It services each request against an internal word RAM with a configurable number of wait states. It returns load data and a stall signal that the pipeline uses to hold its registers.

Parameters:
DATA_W, 10, data word width
ADDR_W, 10, request address width
DEPTH_LOG2, 8, log2 of RAM words (256 words); must be <= ADDR_W
WAIT_STATES, 2, extra wait cycles per access; legal range 0..7

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req_re  in  1  load request (level)
req_we  in  1  store request (level)
req_addr  in  ADDR_W  word address (ALU result)
req_wdata  in  DATA_W  store data
rdata  out  DATA_W  load data, registered
rdata_valid  out  1  one-cycle pulse: rdata updated by a load
stall  out  1  pipeline must hold request and its registers
err  out  1  one-cycle pulse in DONE: bad address or re&we conflict

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, rdata=0, rdata_valid=0, err=0, stall=0. RAM contents are not cleared. Reset during WAIT aborts the access with no RAM write.
- FSM states:
  - IDLE:
    - req = req_re|req_we.
    - If req=1: capture addr, wdata, re, we and load cnt=WAIT_STATES.
    - Next state is DONE if WAIT_STATES==0, otherwise WAIT.
  - WAIT:
    - cnt decrements each cycle.
    - When cnt==1, the next state is DONE.
  - DONE:
    - Lasts one cycle, then unconditionally returns to IDLE.
- Access timing: the access is performed on the clock edge entering DONE.
  - Store: mem[addr] <= wdata.
  - Load: rdata <= mem[addr].
- stall = (state==IDLE & req) | (state==WAIT). stall is combinational from req in IDLE and is 0 in DONE.
  - Stall cycles per access = WAIT_STATES+1.
  - Load data is visible in cycle WAIT_STATES+1, counting the request cycle as 0.
- In DONE:
  - rdata_valid=1 only if the captured op was a load.
  - err=1 per the error rules below.
- rdata holds its last load value until the next successful or out-of-range load.
- Requests are level-sensitive. A request still asserted in the cycle after DONE (back in IDLE) is a new access. The requester must advance or drop the request when stall falls.
- Captured values are used for the access. Request input changes during WAIT are ignored.
- Out-of-range: an address with any bit above DEPTH_LOG2-1 set gives:
  - store: no RAM write;
  - load: rdata <= 0 and rdata_valid=1;
  - err=1 in DONE.
- re&we both set: treated as a store only. rdata is unchanged, rdata_valid=0, err=1.
- Width rules:
  - RAM index = addr[DEPTH_LOG2-1:0].
  - cnt is 3 bits and never wraps below 1 while in WAIT.

Decomposition:
- Shared package (cpu10_pkg):
  - DATA_W and ADDR_W constants.
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - Default WAIT_STATES.
- One sub-module, data_ram_sp:
  - single-port synchronous RAM, DEPTH 2**DEPTH_LOG2 x DATA_W;
  - write-enable, registered read;
  - no reset on the array.
- The FSM, counter, error logic and outputs stay in data_mem_responder.

Test Plan:
1. WAIT_STATES=2, store req_we=1, addr=0x005, wdata=0x2A5 at cycle 0 -> stall=1 in cycles 0..2, stall=0 in cycle 3, err=0, rdata_valid=0. Then load addr=0x005 -> rdata=0x2A5 with rdata_valid=1 in cycle 3 of the load.
2. WAIT_STATES=0, back-to-back loads at addr 1 and 2 (preloaded 0x011, 0x022) -> each access has 1 stall cycle. rdata_valid pulses two cycles apart with 0x011 then 0x022.
3. Load addr=0x1FF (bit 8 set, DEPTH_LOG2=8) -> rdata=0x000, rdata_valid=1, err=1 in DONE. A preceding store to 0x1FF leaves mem[0xFF] unchanged.
4. Store to addr 7, wdata=0x3FF; assert reset=0 mid-WAIT -> outputs go to 0 immediately with state IDLE. A later load of addr 7 returns the old value, not 0x3FF.
5. req_re=req_we=1, addr=3, wdata=0x155 -> mem[3]=0x155, err=1, rdata_valid=0, rdata unchanged.
6. Change req_addr and req_wdata during WAIT -> the access uses the captured cycle-0 values.
